rr_mux_arbiter: RTL

- Round-robin arbiter that shares the 16-bit, 7-input datapath select mux among up to 7 requesters.
- Produces the mux's 3-bit select and a one-hot grant, holds ownership while the requester keeps Req high, and enforces a maximum hold time when other requesters are waiting.
- Sits between the requesting units (PC, ALU, memory, I/O ports) and the select input of the 7:1 mux.

---
 rtl/rr_mux_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner selection for the shared 7:1 datapath mux, with a hold-time limit
module rr_mux_arbiter #(
  parameter int N_REQ    = 7,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       sel,
  output logic             valid,
  output logic             preempt,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, sel_n, win;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic pre_n;
  logic [N_REQ-1:0] rot, others;
  function automatic logic [2:0] add7(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= 4'd7 ? 3'(s - 4'd7) : s[2:0];
  endfunction
  // rotate so bit 0 is the requester at ptr; lowest set bit wins
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    win = ptr;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (rot[j]) win = add7(ptr, 3'(j));
  end
  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    pre_n   = 1'b0;
    others  = req & ~({{(N_REQ-1){1'b0}}, 1'b1} << sel);
    case (state)
      IDLE: if (|req) begin
        state_n = GRANT;
        sel_n   = win;
        hold_n  = '0;
      end
      GRANT: begin
        hold_n = hold_cnt == CNT_W'(MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
        if (!req[sel] || (hold_cnt == CNT_W'(MAX_HOLD) && |others)) begin
          state_n = RELEASE;
          ptr_n   = add7(sel, 3'd1);
          pre_n   = req[sel];
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      preempt  <= pre_n;
    end
  end
  assign gnt   = state == GRANT ? {{(N_REQ-1){1'b0}}, 1'b1} << sel : '0;
  assign valid = state == GRANT;
  assign busy  = state != IDLE;
  a_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) valid == |gnt);
  a_sel:    assert property (@(posedge clk) !valid || gnt[sel]);
  a_range:  assert property (@(posedge clk) sel <= 3'd6);
endmodule
